// File: rtl/gobou_act.sv
// gobou_act: multi-lane activation unit for the gobou fully-connected engine.
// Two-stage pipeline: stage 1 captures the beat, stage 2 applies the selected
// activation per lane and updates saturating per-frame statistics counters.
module gobou_act #(
  parameter int LANES      = 4,
  parameter int DWIDTH     = 16,
  parameter int FRAC       = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int CWIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      valid_in,
  input  logic                      last_in,
  input  logic [1:0]                mode_in,
  input  logic [LANES*DWIDTH-1:0]   data_in,
  input  logic                      clr,
  output logic                      valid_out,
  output logic                      last_out,
  output logic [LANES*DWIDTH-1:0]   data_out,
  output logic [CWIDTH-1:0]         neg_count,
  output logic [CWIDTH-1:0]         clip_count
);

  // Width of a per-beat lane count (0..LANES).
  localparam int IW = $clog2(LANES + 1);

  // Clamp ceiling 6.0 in the fixed-point format, saturated to the largest
  // positive element when 6.0 does not fit.
  localparam longint CMAX_RAW = longint'(6) <<< FRAC;
  localparam longint DMAX     = (longint'(1) <<< (DWIDTH - 1)) - 1;
  localparam longint CMAX_L   = (CMAX_RAW > DMAX) ? DMAX : CMAX_RAW;
  localparam logic signed [DWIDTH-1:0] CMAX = CMAX_L[DWIDTH-1:0];

  logic                     r_vld_p1;
  logic                     r_last_p1;
  logic [1:0]               r_mode_p1;
  logic [LANES*DWIDTH-1:0]  r_data_p1;

  logic                     r_vld_p2;
  logic                     r_last_p2;
  logic [LANES*DWIDTH-1:0]  r_data_p2;
  logic [CWIDTH-1:0]        r_neg_p2;
  logic [CWIDTH-1:0]        r_clip_p2;

  logic [LANES*DWIDTH-1:0]  w_act;
  logic [IW-1:0]            w_neg_inc;
  logic [IW-1:0]            w_clip_inc;

  // Activation of a single element; leaky shift is arithmetic so negatives
  // round toward minus infinity.
  function automatic logic signed [DWIDTH-1:0] act_lane(
    input logic signed [DWIDTH-1:0] x,
    input logic [1:0]               m
  );
    logic signed [DWIDTH-1:0] y;
    y = x;
    case (m)
      2'd1:    if (x < 0) y = '0;
      2'd2:    if (x < 0) y = x >>> LEAK_SHIFT;
      2'd3: begin
        if (x < 0)         y = '0;
        else if (x > CMAX) y = CMAX;
      end
      default: y = x;
    endcase
    return y;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CWIDTH-1:0] sat_add(
    input logic [CWIDTH-1:0] base,
    input logic [IW-1:0]     inc
  );
    logic [CWIDTH:0] s;
    s = {1'b0, base} + {{(CWIDTH + 1 - IW){1'b0}}, inc};
    return s[CWIDTH] ? '1 : s[CWIDTH-1:0];
  endfunction

  // ---- stage 1: capture beat; data/mode only move on valid beats
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_mode_p1 <= '0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1  <= valid_in;
      r_last_p1 <= valid_in & last_in;
      if (valid_in) begin
        r_mode_p1 <= mode_in;
        r_data_p1 <= data_in;
      end
    end
  end

  // Per-lane activation and per-beat negative/clip counts from stage 1.
  always_comb begin
    w_act      = '0;
    w_neg_inc  = '0;
    w_clip_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*DWIDTH +: DWIDTH] = act_lane($signed(r_data_p1[i*DWIDTH +: DWIDTH]), r_mode_p1);
      if (r_vld_p1 && r_data_p1[i*DWIDTH + DWIDTH - 1])
        w_neg_inc = w_neg_inc + IW'(1);
      if (r_vld_p1 && (r_mode_p1 == 2'd3) && ($signed(r_data_p1[i*DWIDTH +: DWIDTH]) > CMAX))
        w_clip_inc = w_clip_inc + IW'(1);
    end
  end

  // ---- stage 2: register activated beat and sideband
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      if (r_vld_p1) r_data_p2 <= w_act;
    end
  end

  // Statistics: clr drops the old total but still takes this beat's counts.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_neg_p2  <= '0;
      r_clip_p2 <= '0;
    end else begin
      r_neg_p2  <= sat_add(clr ? '0 : r_neg_p2,  w_neg_inc);
      r_clip_p2 <= sat_add(clr ? '0 : r_clip_p2, w_clip_inc);
    end
  end

  assign valid_out  = r_vld_p2;
  assign last_out   = r_last_p2;
  assign data_out   = r_data_p2;
  assign neg_count  = r_neg_p2;
  assign clip_count = r_clip_p2;

endmodule
